// File: rtl/ptcalc_pkg.sv
// Shared constants, stage record and scale/round/saturate helpers for the pT-calc multiplier.
// The helpers work on a 64-bit signed value, so the product width must stay below 64 bits.
package ptcalc_pkg;

  localparam int unsigned PTCALC_MUL_A_W   = 13;
  localparam int unsigned PTCALC_MUL_B_W   = 13;
  localparam int unsigned PTCALC_MUL_P_W   = PTCALC_MUL_A_W + PTCALC_MUL_B_W;
  localparam int unsigned PTCALC_MUL_TAG_W = 8;

  // Stage record at the default widths. The pipe declares the same layout at its own
  // parameter widths.
  typedef struct packed {
    logic                             valid;
    logic signed [PTCALC_MUL_P_W-1:0] product;
    logic [PTCALC_MUL_TAG_W-1:0]      tag;
  } ptcalc_mul_stage_t;

  // R = (P + 2^(shift-1)) >>> shift, or P itself when shift is 0.
  function automatic logic signed [63:0] ptcalc_scale(input logic signed [63:0] p,
                                                      input int unsigned       shift);
    logic signed [63:0] half;
    if (shift == 0) return p;
    half = 64'sd1 <<< (shift - 1);
    return (p + half) >>> shift;
  endfunction

  // Largest value representable in a w-bit signed field (w < 64).
  function automatic logic signed [63:0] ptcalc_lim(input int unsigned w);
    return (64'sd1 <<< (w - 1)) - 64'sd1;
  endfunction

  // High when the scaled value does not fit a w-bit signed field.
  function automatic logic ptcalc_round_ovf(input logic signed [63:0] p,
                                            input int unsigned       shift,
                                            input int unsigned       w);
    logic signed [63:0] r;
    logic signed [63:0] lim;
    r = ptcalc_scale(p, shift);
    if (w >= 64) return 1'b0;
    lim = ptcalc_lim(w);
    return (r > lim) || (r < ~lim);
  endfunction

  // Scaled value clamped to the w-bit signed range.
  function automatic logic signed [63:0] ptcalc_round_sat(input logic signed [63:0] p,
                                                          input int unsigned       shift,
                                                          input int unsigned       w);
    logic signed [63:0] r;
    logic signed [63:0] lim;
    r = ptcalc_scale(p, shift);
    if (w < 64) begin
      lim = ptcalc_lim(w);
      if (r > lim) r = lim;
      else if (r < ~lim) r = ~lim;
    end
    return r;
  endfunction

endpackage

// File: rtl/ptcalc_mul_round_sat.sv
// Combinational scale / round-half-up / fit stage for the final pipeline register.
// PTCALC_MUL_SAT_EN defined: clamp out-of-range results; otherwise two's-complement wrap.
module ptcalc_mul_round_sat
  import ptcalc_pkg::*;
#(
  parameter int unsigned P_W        = PTCALC_MUL_P_W,
  parameter int unsigned SHIFT      = 0,
  parameter int unsigned DOUT_WIDTH = PTCALC_MUL_P_W
) (
  input  logic signed [P_W-1:0]  product,
  output logic [DOUT_WIDTH-1:0]  dout,
  output logic                   ovf
);

  logic signed [63:0] prod_ext;

  assign prod_ext = {{(64 - P_W){product[P_W-1]}}, product};

`ifdef PTCALC_MUL_SAT_EN
  assign dout = DOUT_WIDTH'(ptcalc_round_sat(prod_ext, SHIFT, DOUT_WIDTH));
`else
  assign dout = DOUT_WIDTH'(ptcalc_scale(prod_ext, SHIFT));
`endif

  assign ovf = ptcalc_round_ovf(prod_ext, SHIFT, DOUT_WIDTH);

endmodule

// File: rtl/ptcalc_mul_pipe.sv
// Pipelined signed multiplier with valid/ready, tag passthrough and scaled, rounded output.
// Stage 1 holds operands, stages 2..NUM_STAGE-1 the product, the last stage the result.
// Optional macro PTCALC_MUL_SAT_EN selects saturation on overflow (default: wrap).
module ptcalc_mul_pipe
  import ptcalc_pkg::*;
#(
  parameter int unsigned A_WIDTH    = PTCALC_MUL_A_W,
  parameter int unsigned B_WIDTH    = PTCALC_MUL_B_W,
  parameter int unsigned DOUT_WIDTH = 26,
  parameter int unsigned SHIFT      = 0,
  parameter int unsigned NUM_STAGE  = 3,
  parameter int unsigned TAG_WIDTH  = PTCALC_MUL_TAG_W
) (
  input  logic                  ap_clk,
  input  logic                  ap_rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [A_WIDTH-1:0]    din0,
  input  logic [B_WIDTH-1:0]    din1,
  input  logic [TAG_WIDTH-1:0]  in_tag,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DOUT_WIDTH-1:0] dout,
  output logic [TAG_WIDTH-1:0]  out_tag,
  output logic                  out_ovf
);

  localparam int unsigned P_W = A_WIDTH + B_WIDTH;

  typedef struct packed {
    logic                  valid;
    logic signed [P_W-1:0] product;
    logic [TAG_WIDTH-1:0]  tag;
  } stage_t;

  logic                  advance;
  logic                  fin_valid;
  logic signed [P_W-1:0] fin_prod;
  logic [TAG_WIDTH-1:0]  fin_tag;
  logic [DOUT_WIDTH-1:0] rs_dout;
  logic                  rs_ovf;
  logic                  out_valid_q;
  logic [DOUT_WIDTH-1:0] dout_q;
  logic [TAG_WIDTH-1:0]  out_tag_q;
  logic                  out_ovf_q;

  // Global stall: the whole pipe moves only when the output slot is free or being consumed.
  assign advance  = !out_valid_q || out_ready;
  assign in_ready = advance;

  if (NUM_STAGE == 1) begin : g_one
    assign fin_valid = in_valid;
    assign fin_prod  = P_W'($signed(din0)) * P_W'($signed(din1));
    assign fin_tag   = in_tag;
  end else begin : g_multi
    logic                      op_valid_q;
    logic signed [A_WIDTH-1:0] op_a_q;
    logic signed [B_WIDTH-1:0] op_b_q;
    logic [TAG_WIDTH-1:0]      op_tag_q;
    logic signed [P_W-1:0]     op_prod;

    // Operand register; only the valid bit needs a reset value.
    always_ff @(posedge ap_clk) begin
      if (ap_rst) begin
        op_valid_q <= 1'b0;
      end else if (advance) begin
        op_valid_q <= in_valid;
        op_a_q     <= din0;
        op_b_q     <= din1;
        op_tag_q   <= in_tag;
      end
    end

    assign op_prod = P_W'(op_a_q) * P_W'(op_b_q);

    if (NUM_STAGE == 2) begin : g_direct
      assign fin_valid = op_valid_q;
      assign fin_prod  = op_prod;
      assign fin_tag   = op_tag_q;
    end else begin : g_prod
      localparam int unsigned NumProd = NUM_STAGE - 2;
      stage_t prod_q [NumProd];

      // Product shift register feeding the final stage.
      always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
          for (int i = 0; i < NumProd; i++) prod_q[i].valid <= 1'b0;
        end else if (advance) begin
          prod_q[0] <= '{valid: op_valid_q, product: op_prod, tag: op_tag_q};
          for (int i = 1; i < NumProd; i++) prod_q[i] <= prod_q[i-1];
        end
      end

      assign fin_valid = prod_q[NumProd-1].valid;
      assign fin_prod  = prod_q[NumProd-1].product;
      assign fin_tag   = prod_q[NumProd-1].tag;
    end
  end

  ptcalc_mul_round_sat #(
    .P_W        (P_W),
    .SHIFT      (SHIFT),
    .DOUT_WIDTH (DOUT_WIDTH)
  ) u_round_sat (
    .product (fin_prod),
    .dout    (rs_dout),
    .ovf     (rs_ovf)
  );

  // Final result register; holds while stalled.
  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      out_valid_q <= 1'b0;
      dout_q      <= '0;
      out_tag_q   <= '0;
      out_ovf_q   <= 1'b0;
    end else if (advance) begin
      out_valid_q <= fin_valid;
      dout_q      <= rs_dout;
      out_tag_q   <= fin_tag;
      out_ovf_q   <= rs_ovf;
    end
  end

  assign out_valid = out_valid_q;
  assign dout      = dout_q;
  assign out_tag   = out_tag_q;
  assign out_ovf   = out_ovf_q;

endmodule

// File: tb/tb_ptcalc_mul_pipe.sv
// Scoreboard bench for ptcalc_mul_pipe: three instances (default depth 3, scaled depth 5,
// depth 1) share operands; expected results are queued on transfer and popped on consume.
module tb_ptcalc_mul_pipe;

  localparam int NA = 3;
  localparam int NB = 5;
  localparam int NC = 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        ap_rst;
  logic [12:0] din0, din1;
  logic [7:0]  in_tag;
  logic        iv_a, iv_b, iv_c, ir_a, ir_b, ir_c;
  logic        ov_a, ov_b, ov_c, or_a, or_b, or_c;
  logic [25:0] dout_a, dout_c;
  logic [15:0] dout_b;
  logic [7:0]  ot_a, ot_b, ot_c;
  logic        of_a, of_b, of_c;

  ptcalc_mul_pipe #(.NUM_STAGE(NA)) u_a (
    .ap_clk(clk), .ap_rst(ap_rst), .in_valid(iv_a), .in_ready(ir_a), .din0(din0), .din1(din1),
    .in_tag(in_tag), .out_valid(ov_a), .out_ready(or_a), .dout(dout_a), .out_tag(ot_a),
    .out_ovf(of_a));

  ptcalc_mul_pipe #(.DOUT_WIDTH(16), .SHIFT(8), .NUM_STAGE(NB)) u_b (
    .ap_clk(clk), .ap_rst(ap_rst), .in_valid(iv_b), .in_ready(ir_b), .din0(din0), .din1(din1),
    .in_tag(in_tag), .out_valid(ov_b), .out_ready(or_b), .dout(dout_b), .out_tag(ot_b),
    .out_ovf(of_b));

  ptcalc_mul_pipe #(.NUM_STAGE(NC)) u_c (
    .ap_clk(clk), .ap_rst(ap_rst), .in_valid(iv_c), .in_ready(ir_c), .din0(din0), .din1(din1),
    .in_tag(in_tag), .out_valid(ov_c), .out_ready(or_c), .dout(dout_c), .out_tag(ot_c),
    .out_ovf(of_c));

  typedef struct {
    longint     dout;
    logic [7:0] tag;
    logic       ovf;
    int         issue;
    bit         lat;
  } exp_t;

  exp_t   q_a[$], q_b[$], q_c[$];
  exp_t   ne, e;
  longint cur_a, cur_b, cur_c;
  logic   co_a, co_b, co_c;
  bit     lat_chk;
  int     cyc = 0;
  int     n_cmp = 0;
  int     n_err = 0;

  bit         stall_a = 1'b0;
  logic [25:0] h_dout;
  logic [7:0]  h_tag;
  logic        h_ovf;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic spurious(input string name);
    n_cmp++;
    n_err++;
    $display("FAIL %s: output presented with no expected result queued", name);
  endtask

  // Reference: floor division for the rounding shift, then clamp or wrap.
  task automatic ref_model(input longint p, input int shift, input int dw,
                           output longint d, output logic ovf);
    longint num, den, r, mx, mn;
    if (shift == 0) begin
      r = p;
    end else begin
      num = p + (longint'(1) << (shift - 1));
      den = longint'(1) << shift;
      r   = num / den;
      if ((num % den != 0) && (num < 0)) r = r - 1;
    end
    mx  = (longint'(1) << (dw - 1)) - 1;
    mn  = -(longint'(1) << (dw - 1));
    ovf = (r > mx) || (r < mn);
`ifdef PTCALC_MUL_SAT_EN
    d = (r > mx) ? mx : ((r < mn) ? mn : r);
`else
    d = r & ((longint'(1) << dw) - 1);
    if (d > mx) d = d - (longint'(1) << dw);
`endif
  endtask

  task automatic send(input int a, input int b, input int t, input logic [2:0] sel,
                      input longint ea, input logic oa, input longint eb, input logic ob,
                      input longint ec, input logic oc);
    int  waited;
    bit  done;
    @(posedge clk);
    #1;
    din0 = 13'(a);
    din1 = 13'(b);
    in_tag = 8'(t);
    iv_a = sel[0];
    iv_b = sel[1];
    iv_c = sel[2];
    cur_a = ea; co_a = oa;
    cur_b = eb; co_b = ob;
    cur_c = ec; co_c = oc;
    waited = 0;
    done = 1'b0;
    while (!done) begin
      @(negedge clk);
      if ((!sel[0] || ir_a) && (!sel[1] || ir_b) && (!sel[2] || ir_c)) begin
        done = 1'b1;
      end else begin
        waited++;
        if (waited > 50) begin
          chk("in_ready_timeout", longint'(waited), 0);
          done = 1'b1;
        end
      end
    end
  endtask

  task automatic idle();
    @(posedge clk);
    #1;
    iv_a = 1'b0;
    iv_b = 1'b0;
    iv_c = 1'b0;
  endtask

  // Directed vector: hand-computed results for the 26-bit and the 16-bit/shift-8 builds.
  task automatic dvec(input int a, input int b, input int t, input longint ea,
                      input longint eb_sat, input longint eb_wrap, input logic ob);
    longint eb;
`ifdef PTCALC_MUL_SAT_EN
    eb = eb_sat;
`else
    eb = eb_wrap;
`endif
    send(a, b, t, 3'b111, ea, 1'b0, eb, ob, ea, 1'b0);
  endtask

  task automatic rvec(input int a, input int b, input int t, input logic [2:0] sel);
    longint p, da, db, dc;
    logic   oa, ob, oc;
    p = longint'(a) * longint'(b);
    ref_model(p, 0, 26, da, oa);
    ref_model(p, 8, 16, db, ob);
    ref_model(p, 0, 26, dc, oc);
    send(a, b, t, sel, da, oa, db, ob, dc, oc);
  endtask

  function automatic int pick_a();
    int r;
    r = int'($urandom_range(0, 7));
    if (r == 0) return -4096;
    if (r == 1) return 4095;
    return int'($urandom_range(0, 8191)) - 4096;
  endfunction

  task automatic cmp_out(input string nm, input longint d, input logic [7:0] tg,
                         input logic ov, input exp_t x, input int n);
    chk({nm, "_dout"}, d, x.dout);
    chk({nm, "_tag"}, longint'(tg), longint'(x.tag));
    chk({nm, "_ovf"}, longint'(ov), longint'(x.ovf));
    if (x.lat) chk({nm, "_latency"}, longint'(cyc - x.issue), longint'(n));
  endtask

  // Stimulus side of the scoreboard: queue the expected result on each transfer.
  always @(negedge clk) begin
    if (!ap_rst) begin
      ne.tag = in_tag; ne.issue = cyc; ne.lat = lat_chk;
      if (iv_a && ir_a) begin ne.dout = cur_a; ne.ovf = co_a; q_a.push_back(ne); end
      if (iv_b && ir_b) begin ne.dout = cur_b; ne.ovf = co_b; q_b.push_back(ne); end
      if (iv_c && ir_c) begin ne.dout = cur_c; ne.ovf = co_c; q_c.push_back(ne); end
    end
  end

  // Monitor: compare each consumed result and check output stability under stall.
  always @(negedge clk) begin
    if (ap_rst) begin
      q_a.delete();
      q_b.delete();
      q_c.delete();
      stall_a = 1'b0;
    end else begin
      if (ov_a && or_a) begin
        if (q_a.size() == 0) spurious("a_out");
        else begin e = q_a.pop_front(); cmp_out("a", longint'($signed(dout_a)), ot_a, of_a, e, NA); end
      end
      if (ov_b && or_b) begin
        if (q_b.size() == 0) spurious("b_out");
        else begin e = q_b.pop_front(); cmp_out("b", longint'($signed(dout_b)), ot_b, of_b, e, NB); end
      end
      if (ov_c && or_c) begin
        if (q_c.size() == 0) spurious("c_out");
        else begin e = q_c.pop_front(); cmp_out("c", longint'($signed(dout_c)), ot_c, of_c, e, NC); end
      end
      if (stall_a) begin
        chk("a_hold_valid", longint'(ov_a), 1);
        chk("a_hold_dout", longint'(dout_a), longint'(h_dout));
        chk("a_hold_tag", longint'(ot_a), longint'(h_tag));
        chk("a_hold_ovf", longint'(of_a), longint'(h_ovf));
      end
      if (ov_a && !or_a) begin
        chk("a_in_ready_stall", longint'(ir_a), 0);
        stall_a = 1'b1;
        h_dout = dout_a;
        h_tag = ot_a;
        h_ovf = of_a;
      end else begin
        stall_a = 1'b0;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    ap_rst = 1'b1;
    iv_a = 1'b0; iv_b = 1'b0; iv_c = 1'b0;
    or_a = 1'b1; or_b = 1'b1; or_c = 1'b1;
    din0 = '0; din1 = '0; in_tag = '0;
    cur_a = 0; cur_b = 0; cur_c = 0;
    co_a = 1'b0; co_b = 1'b0; co_c = 1'b0;
    lat_chk = 1'b1;
    repeat (3) @(posedge clk);
    #1 ap_rst = 1'b0;
    @(negedge clk);
    chk("rst_a_valid", longint'(ov_a), 0);
    chk("rst_a_dout", longint'(dout_a), 0);
    chk("rst_a_tag", longint'(ot_a), 0);
    chk("rst_a_ovf", longint'(of_a), 0);
    chk("rst_a_in_ready", longint'(ir_a), 1);
    chk("rst_b_valid", longint'(ov_b), 0);
    chk("rst_b_dout", longint'(dout_b), 0);
    chk("rst_c_valid", longint'(ov_c), 0);

    // Directed: a, b, tag, 26-bit result, 16-bit/shift-8 saturated, wrapped, 16-bit ovf.
    dvec(-4096, -4096, 'h5A, 16777216, 32767, 0, 1'b1);
    dvec(4095, -4096, 'h11, -16773120, -32768, 16, 1'b1);
    dvec(1000, 1000, 'h22, 1000000, 3906, 3906, 1'b0);
    dvec(3, 43, 'h33, 129, 1, 1, 1'b0);
    dvec(-3, 43, 'h44, -129, -1, -1, 1'b0);
    dvec(8, 16, 'h55, 128, 1, 1, 1'b0);
    dvec(-8, 16, 'h66, -128, 0, 0, 1'b0);
    dvec(127, 1, 'h77, 127, 0, 0, 1'b0);
    dvec(-4096, 2048, 'h88, -8388608, -32768, -32768, 1'b0);
    dvec(4095, 2049, 'h99, 8390655, 32767, -32760, 1'b1);
    dvec(-4096, 2049, 'hAA, -8392704, -32768, 32752, 1'b1);
    dvec(0, -4096, 'hBB, 0, 0, 0, 1'b0);

    // Random sweep over all three depths, corners included.
    for (int i = 0; i < 40; i++) rvec(pick_a(), pick_a(), i, 3'b111);
    idle();
    repeat (8) @(posedge clk);

    // Backpressure on the depth-3 instance: 10 back-to-back operands, 5-cycle stall.
    lat_chk = 1'b0;
    fork
      begin
        for (int i = 0; i < 10; i++) rvec(pick_a(), pick_a(), 'hA0 + i, 3'b001);
        idle();
      end
      begin
        repeat (4) @(posedge clk);
        #1 or_a = 1'b0;
        repeat (5) @(posedge clk);
        #1 or_a = 1'b1;
      end
    join
    repeat (12) @(posedge clk);

    // Reset with two results in flight; neither may appear afterwards.
    lat_chk = 1'b1;
    rvec(100, 3, 'hC1, 3'b001);
    rvec(-5, 7, 'hC2, 3'b001);
    @(posedge clk);
    #1;
    iv_a = 1'b0;
    ap_rst = 1'b1;
    @(posedge clk);
    #1 ap_rst = 1'b0;
    @(negedge clk);
    chk("mid_rst_a_valid", longint'(ov_a), 0);
    chk("mid_rst_a_dout", longint'(dout_a), 0);
    chk("mid_rst_a_tag", longint'(ot_a), 0);
    chk("mid_rst_a_in_ready", longint'(ir_a), 1);
    rvec(77, -9, 'h3C, 3'b001);
    idle();

    for (int k = 0; k < 200; k++) begin
      if (q_a.size() == 0 && q_b.size() == 0 && q_c.size() == 0) break;
      @(negedge clk);
    end
    repeat (8) @(negedge clk);
    chk("drain_q_a", longint'(q_a.size()), 0);
    chk("drain_q_b", longint'(q_b.size()), 0);
    chk("drain_q_c", longint'(q_c.size()), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/ptcalc_mul_pipe.md
# ptcalc_mul_pipe

Parametrised, pipelined signed multiplier for the pT-calculation datapath, replacing the fixed 13×13 combinational product. It adds a valid/ready handshake, a configurable pipeline depth for timing closure on VU13P, a tag passthrough, and post-product scaling with round-half-up and overflow detection to a reduced output width. It sits between the segment-parameter stage and the pT LUT/accumulator stages.

## Interface
- A_WIDTH, 13: signed width of operand a.
- B_WIDTH, 13: signed width of operand b.
- DOUT_WIDTH, 26: signed result width.
- SHIFT, 0: right-shift applied to the full product (0 ≤ SHIFT < A_WIDTH+B_WIDTH).
- NUM_STAGE, 3: pipeline depth in cycles (≥1).
- TAG_WIDTH, 8: width of the sideband tag carried alongside each product.

Ports:
- ap_clk  in  1: clock; all logic rising-edge.
- ap_rst  in  1: reset, synchronous, active-high.
- in_valid  in  1: operands valid.
- in_ready  out  1: block accepts operands this cycle.
- din0  in  A_WIDTH: signed operand a.
- din1  in  B_WIDTH: signed operand b.
- in_tag  in  TAG_WIDTH: sideband, returned unchanged with the result.
- out_valid  out  1: result valid.
- out_ready  in  1: downstream accepts result.
- dout  out  DOUT_WIDTH: scaled, rounded signed result.
- out_tag  out  TAG_WIDTH: tag of this result.
- out_ovf  out  1: the scaled result did not fit in DOUT_WIDTH.

## Operation
- Full product P = din0 × din1, signed, A_WIDTH+B_WIDTH bits; no intermediate truncation.
- Scaling: if SHIFT>0, R = (P + 2^(SHIFT−1)) >>> SHIFT (arithmetic, round half toward +∞); if SHIFT=0, R = P. The rounding add is done at A_WIDTH+B_WIDTH+1 bits and never overflows.
- Fit check: out_ovf=1 iff R lies outside [−2^(DOUT_WIDTH−1), 2^(DOUT_WIDTH−1)−1]. Behaviour on overflow is selected under Configuration.
- If DOUT_WIDTH ≥ width of R, R is sign-extended and out_ovf is constant 0.
- Each stage holds valid, data and tag. Stage 1 registers the operands. The final stage holds dout, out_tag and out_ovf.
- Global stall: advance = !out_valid || out_ready. All stages shift only when advance=1. in_ready = advance. Internal bubbles are not collapsed.
- A transfer occurs on in_valid && in_ready. A result is consumed on out_valid && out_ready.
- Data and tag in a stage whose valid bit is 0 are don't-care. Valid bits are always exact.

## Timing
- Latency is NUM_STAGE cycles from input transfer to out_valid, with no stalls. Throughput is 1 per cycle while out_ready=1.
- While out_valid=1 && out_ready=0: dout, out_tag, out_ovf and out_valid hold stable, and in_ready=0 in the same cycle (combinational path from out_ready).
- Simultaneous accept and consume on a full pipeline is allowed, with no bubble inserted.
- Reset: all stage valid bits and out_valid go to 0; dout, out_tag and out_ovf go to 0.
- in_ready is 1 in the first cycle after ap_rst deasserts.
- Assertion of ap_rst mid-stream drops all in-flight results; no partial output appears.
- Product-to-result logic is split across stages: the multiply spans stages 1..NUM_STAGE−1 (DSP48 AREG/MREG/PREG friendly), and rounding, saturation and overflow are done in the final stage. With NUM_STAGE=1 everything sits in one register stage.

## Configuration
- PTCALC_MUL_SAT_EN defined: on overflow, dout clamps to 2^(DOUT_WIDTH−1)−1 (R>max) or −2^(DOUT_WIDTH−1) (R<min), and out_ovf=1.
- PTCALC_MUL_SAT_EN undefined: dout = R[DOUT_WIDTH−1:0] (two's-complement wrap). out_ovf is still computed and reported.

## Structure
- The shared package ptcalc_pkg holds:
  - default width constants (PTCALC_MUL_A_W=13, PTCALC_MUL_B_W=13);
  - the stage record typedef (valid, product, tag);
  - the function for rounding and saturation.
- One sub-module, ptcalc_mul_round_sat: a combinational scale/round/fit stage, parametrised by product width, SHIFT and DOUT_WIDTH, and instantiated in the final stage.

## Test plan
- Defaults, out_ready=1: din0=−4096, din1=−4096, tag=0x5A → after 3 cycles dout=16777216, out_tag=0x5A, out_ovf=0. Then din0=4095, din1=−4096 → dout=−16773120.
- DOUT_WIDTH=16, SHIFT=8: 1000×1000 → 3906. 3×43 → 1. −3×43 → −1. Each has out_ovf=0.
- DOUT_WIDTH=16, SHIFT=8, −4096×−4096 → out_ovf=1. dout=32767 with PTCALC_MUL_SAT_EN, dout=0 without.
- Backpressure: stream 10 tagged operands back-to-back, drop out_ready for 5 cycles mid-stream → in_ready falls in the same cycle, output holds stable, all 10 results arrive in order with correct tags, none duplicated or lost.
- Reset mid-stream: 2 results in flight, pulse ap_rst for 1 cycle → out_valid=0, dout=0, no stale result ever appears, and the next operand emerges after NUM_STAGE cycles.
- NUM_STAGE=1 and NUM_STAGE=5 sweeps with random operands (including −2^(A_WIDTH−1) corners) → results match the reference model and latency equals NUM_STAGE.
